regfile_writeback: RTL



---
 rtl/y86_pkg.sv | 31 +++
 rtl/reg_dst_decode.sv | 46 ++++
 rtl/regfile_writeback.sv | 113 +++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs and status encoding.
package y86_pkg;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OP    = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [3:0] R_RSP   = 4'h4;
    localparam logic [3:0] R_NONE  = 4'hF;

    typedef enum logic [1:0] {
        StatAok = 2'd0,
        StatHlt = 2'd1,
        StatIns = 2'd2
    } stat_e;

    // Anything above POP is not a defined instruction.
    function automatic logic is_invalid(input logic [3:0] ic);
        return ic > I_POP;
    endfunction

endpackage

// File: rtl/reg_dst_decode.sv
// Combinational source/destination register selection from icode, rA, rB and cond.
module reg_dst_decode
    import y86_pkg::*;
(
    input  logic [3:0] i_icode,
    input  logic [3:0] i_ra,
    input  logic [3:0] i_rb,
    input  logic       i_cond,
    output logic [3:0] o_src_a,
    output logic [3:0] o_src_b,
    output logic [3:0] o_dst_e,
    output logic [3:0] o_dst_m
);

    always_comb begin
        o_src_a = R_NONE;
        o_src_b = R_NONE;
        o_dst_e = R_NONE;
        o_dst_m = R_NONE;

        case (i_icode)
            I_CMOV, I_RMMOV, I_OP, I_PUSH: o_src_a = i_ra;
            I_RET, I_POP:                  o_src_a = R_RSP;
            default:                       o_src_a = R_NONE;
        endcase

        case (i_icode)
            I_RMMOV, I_MRMOV, I_OP:        o_src_b = i_rb;
            I_CALL, I_RET, I_PUSH, I_POP:  o_src_b = R_RSP;
            default:                       o_src_b = R_NONE;
        endcase

        case (i_icode)
            I_CMOV:                        o_dst_e = i_cond ? i_rb : R_NONE;
            I_IRMOV, I_OP:                 o_dst_e = i_rb;
            I_CALL, I_RET, I_PUSH, I_POP:  o_dst_e = R_RSP;
            default:                       o_dst_e = R_NONE;
        endcase

        case (i_icode)
            I_MRMOV, I_POP:                o_dst_m = i_ra;
            default:                       o_dst_m = R_NONE;
        endcase
    end

endmodule

// File: rtl/regfile_writeback.sv
// Y86-64 register file, write-back and sticky status machine.
// Optional macro WB_BYPASS_EN makes reads see same-cycle committed write data.
module regfile_writeback
    import y86_pkg::*;
#(
    parameter int unsigned NREG  = 15,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wb_valid,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             cond,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valM,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    output logic [1:0]       stat,
    output logic             halted
);

    logic [WIDTH-1:0] r_regs [NREG];
    stat_e            r_stat;
    stat_e            w_stat_next;
    logic [3:0]       w_src_a;
    logic [3:0]       w_src_b;
    logic [3:0]       w_dst_e;
    logic [3:0]       w_dst_m;
    logic             w_commit;

    reg_dst_decode u_decode (
        .i_icode (icode),
        .i_ra    (rA),
        .i_rb    (rB),
        .i_cond  (cond),
        .o_src_a (w_src_a),
        .o_src_b (w_src_b),
        .o_dst_e (w_dst_e),
        .o_dst_m (w_dst_m)
    );

    // The halting/invalid instruction itself never writes registers.
    assign w_commit = wb_valid && (r_stat == StatAok) && (icode != I_HALT) && !is_invalid(icode);

    always_comb begin
        w_stat_next = r_stat;
        if (wb_valid && (r_stat == StatAok)) begin
            if (icode == I_HALT) begin
                w_stat_next = StatHlt;
            end else if (is_invalid(icode)) begin
                w_stat_next = StatIns;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat <= StatAok;
        end else begin
            r_stat <= w_stat_next;
        end
    end

    // valM is checked first so it wins when dstE == dstM.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < int'(NREG); i++) begin
                if (w_dst_m == 4'(i)) begin
                    r_regs[i] <= valM;
                end else if (w_dst_e == 4'(i)) begin
                    r_regs[i] <= valE;
                end
            end
        end
    end

    always_comb begin
        valA = '0;
        valB = '0;
        if (int'(w_src_a) < int'(NREG)) begin
            valA = r_regs[w_src_a];
        end
        if (int'(w_src_b) < int'(NREG)) begin
            valB = r_regs[w_src_b];
        end
`ifdef WB_BYPASS_EN
        if (w_commit && (w_src_a != R_NONE)) begin
            if (w_src_a == w_dst_m) begin
                valA = valM;
            end else if (w_src_a == w_dst_e) begin
                valA = valE;
            end
        end
        if (w_commit && (w_src_b != R_NONE)) begin
            if (w_src_b == w_dst_m) begin
                valB = valM;
            end else if (w_src_b == w_dst_e) begin
                valB = valE;
            end
        end
`endif
    end

    assign stat   = r_stat;
    assign halted = (r_stat != StatAok);

endmodule
